fetch_stall_unit: RTL and testbench

Instruction-fetch stage with PC register, internal instruction ROM and IF/ID pipeline register, built to replace the plain fetch stage. Adds load-use stall and flush control on top of the MEM-stage branch redirect. Sits directly upstream of decode, which consumes if_id_instr/if_id_npc; the redirect inputs come from the MEM stage's PCSrc/branch_addr outputs.

---
 rtl/fetch_stall_unit.sv | 116 +++++++++++
 tb/tb_fetch_stall_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: PC register, instruction ROM and IF/ID register.
// Supports MEM-stage redirect, load-use stall and IF/ID flush.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   ex_mem_pc_src   redirect request from MEM stage
//   ex_mem_npc      redirect target (low 2 bits dropped)
//   stall           hold PC and IF/ID
//   flush           bubble into IF/ID, PC advances
//   if_id_instr     IF/ID instruction
//   if_id_npc       IF/ID PC+4
//   if_id_valid     IF/ID holds a real fetch
//   pc_out          address being fetched
//   fetch_count     valid instructions written to IF/ID
//
// ROM contents come from IMEM_INIT, a packed image with word i
// in bits [32*i +: 32]. Words past IMEM_DEPTH read NOP_INSTR.
module fetch_stall_unit #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_pc_src,
  input  logic [31:0] ex_mem_npc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic [31:0] pc_out,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   npc_q, npc_d;
  logic          valid_q, valid_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [31:0]   pc_plus4;
  logic [AW-1:0] rom_idx;
  logic          rom_hit;
  logic [31:0]   rom_word;
  logic          unused_npc_lsb;

  assign unused_npc_lsb = ^ex_mem_npc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  // Any address bit above the ROM window means out of range;
  // such reads return the bubble rather than aliasing.
  assign rom_idx  = pc_q[AW+1:2];
  assign rom_hit  = (pc_q >> (AW + 2)) == 32'd0;
  assign rom_word = rom_hit
                  ? IMEM_INIT[32*int'(rom_idx) +: 32]
                  : NOP_INSTR;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (ex_mem_pc_src) begin
      pc_d    = {ex_mem_npc[31:2], 2'b00};
      instr_d = NOP_INSTR;
      npc_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      // Flush still empties IF/ID, but PC stays put.
      if (flush) begin
        instr_d = NOP_INSTR;
        npc_d   = 32'd0;
        valid_d = 1'b0;
      end
    end else if (flush) begin
      pc_d    = pc_plus4;
      instr_d = NOP_INSTR;
      npc_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = rom_word;
      npc_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_npc   = npc_q;
  assign if_id_valid = valid_q;
  assign pc_out      = pc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// tb_fetch_stall_unit: directed checks of fetch, stall,
// flush, redirect, PC wrap and async reset.
module tb_fetch_stall_unit;

  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  function automatic logic [31:0] rom_w(input int n);
    logic [31:0] w;
    case (n)
      0:       w = 32'h8C01_0000;
      1:       w = 32'h0022_1820;
      2:       w = 32'hAC03_0004;
      default: w = 32'hA000_0000 | 32'(n);
    endcase
    return w;
  endfunction

  function automatic logic [DEPTH*32-1:0] mk_rom();
    logic [DEPTH*32-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++)
      r[i*32 +: 32] = rom_w(i);
    return r;
  endfunction

  localparam logic [DEPTH*32-1:0] ROM = mk_rom();

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] tgt;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] cnt;

  int n_chk;
  int n_err;

  fetch_stall_unit #(
    .IMEM_DEPTH(DEPTH),
    .NOP_INSTR (NOP),
    .IMEM_INIT (ROM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_pc_src(pc_src),
    .ex_mem_npc   (tgt),
    .stall        (stall),
    .flush        (flush),
    .if_id_instr  (instr),
    .if_id_npc    (npc),
    .if_id_valid  (valid),
    .pc_out       (pc),
    .fetch_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] e_instr,
                         input logic [31:0] e_npc,
                         input logic        e_valid,
                         input logic [31:0] e_pc,
                         input logic [31:0] e_cnt);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".npc"},   npc,   e_npc);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    chk({tag, ".pc"},    pc,    e_pc);
    chk({tag, ".cnt"},   cnt,   e_cnt);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst    = 1'b1;
    pc_src = 1'b0;
    tgt    = 32'd0;
    stall  = 1'b0;
    flush  = 1'b0;
    #12;
    chk_all("reset", NOP, 32'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;

    tick();
    chk_all("fetch0", rom_w(0), 32'd4, 1'b1, 32'd4, 32'd1);
    tick();
    chk_all("fetch1", rom_w(1), 32'd8, 1'b1, 32'd8, 32'd2);

    stall = 1'b1;
    tick();
    chk_all("stall1", rom_w(1), 32'd8, 1'b1, 32'd8, 32'd2);
    tick();
    chk_all("stall2", rom_w(1), 32'd8, 1'b1, 32'd8, 32'd2);
    stall = 1'b0;
    tick();
    chk_all("fetch2", rom_w(2), 32'd12, 1'b1, 32'd12, 32'd3);

    pc_src = 1'b1;
    tgt    = 32'h0000_0043;
    stall  = 1'b1;
    tick();
    chk_all("redir", NOP, 32'd0, 1'b0, 32'h40, 32'd3);
    pc_src = 1'b0;
    stall  = 1'b0;
    tick();
    chk_all("redir_tgt", rom_w(16), 32'h44, 1'b1, 32'h44, 32'd4);

    pc_src = 1'b1;
    tgt    = 32'h0000_000C;
    tick();
    chk_all("redir_c", NOP, 32'd0, 1'b0, 32'h0C, 32'd4);
    pc_src = 1'b0;
    tick();
    chk_all("fetch3", rom_w(3), 32'h10, 1'b1, 32'h10, 32'd5);
    flush = 1'b1;
    tick();
    chk_all("flush", NOP, 32'd0, 1'b0, 32'h14, 32'd5);
    flush = 1'b0;
    tick();
    chk_all("fetch5", rom_w(5), 32'h18, 1'b1, 32'h18, 32'd6);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    chk_all("flush_stall", NOP, 32'd0, 1'b0, 32'h18, 32'd6);
    flush = 1'b0;
    stall = 1'b0;
    tick();
    chk_all("fetch6", rom_w(6), 32'h1C, 1'b1, 32'h1C, 32'd7);

    pc_src = 1'b1;
    tgt    = 32'hFFFF_FFFC;
    tick();
    chk_all("redir_top", NOP, 32'd0, 1'b0, 32'hFFFF_FFFC, 32'd7);
    pc_src = 1'b0;
    tick();
    chk_all("oor_wrap", NOP, 32'd0, 1'b1, 32'd0, 32'd8);
    tick();
    chk_all("after_wrap", rom_w(0), 32'd4, 1'b1, 32'd4, 32'd9);

    stall = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", NOP, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    chk_all("rst_hold", NOP, 32'd0, 1'b0, 32'd0, 32'd0);
    stall = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    chk_all("post_rst", rom_w(0), 32'd4, 1'b1, 32'd4, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
